lorenz_sample_drain: RTL and testbench

Consumer end of the Lorenz integrator array. The block paces the integrators through a step enable and decimates their x/y/z state. Each retained sample is converted from Q(SIZE-PNT).PNT to a narrow screen-scale fixed-point word and buffered in a small FIFO. The FIFO is drained over a valid/ready stream by the pixel/host writer. A full FIFO halts stepping, so no trajectory point is lost.

---
 rtl/lorenz_sample_drain.sv | 153 +++++++++++++++
 tb/tb_lorenz_sample_drain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lorenz_sample_drain.sv
// Lorenz integrator consumer: paces stepping, decimates x/y/z, converts to screen scale, buffers in a FWFT FIFO.
// Define LORENZ_SAT_EN to clamp out-of-range coordinates (and flag overflow) instead of wrapping them.
module lorenz_sample_drain #(
  parameter int SIZE  = 64,
  parameter int PNT   = 48,
  parameter int OUT_W = 16,
  parameter int OSH   = 8,
  parameter int DEPTH = 8,
  parameter int DEC_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
  input  logic [DEC_W-1:0]             decim,
  input  logic [SIZE-1:0]              x_in,
  input  logic [SIZE-1:0]              y_in,
  input  logic [SIZE-1:0]              z_in,
  output logic                         step,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_W-1:0]             m_x,
  output logic [OUT_W-1:0]             m_y,
  output logic [OUT_W-1:0]             m_z,
  output logic [15:0]                  m_seq,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [1:0]                   fsm_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SH = PNT - OSH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  state_t state, state_n;

  logic [DEC_W-1:0] dec_cnt;
  logic [15:0]      seq_cnt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_n;
  logic             push, pop;

  logic [OUT_W-1:0] mem_x [DEPTH];
  logic [OUT_W-1:0] mem_y [DEPTH];
  logic [OUT_W-1:0] mem_z [DEPTH];
  logic [15:0]      mem_seq [DEPTH];

  logic signed [SIZE-1:0] sx, sy, sz;
  logic [OUT_W-1:0]       cx, cy, cz;

  assign sx = $signed(x_in) >>> SH;
  assign sy = $signed(y_in) >>> SH;
  assign sz = $signed(z_in) >>> SH;

`ifdef LORENZ_SAT_EN
  localparam logic signed [SIZE-1:0] OMAX = {{(SIZE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SIZE-1:0] OMIN = {{(SIZE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic sat_x, sat_y, sat_z;

  // Returns {saturated, clamped value}.
  function automatic logic [OUT_W:0] clamp(input logic signed [SIZE-1:0] v);
    if (v > OMAX)      clamp = {1'b1, OMAX[OUT_W-1:0]};
    else if (v < OMIN) clamp = {1'b1, OMIN[OUT_W-1:0]};
    else               clamp = {1'b0, v[OUT_W-1:0]};
  endfunction

  assign {sat_x, cx} = clamp(sx);
  assign {sat_y, cy} = clamp(sy);
  assign {sat_z, cz} = clamp(sz);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (push && (sat_x || sat_y || sat_z)) overflow <= 1'b1;
  end
`else
  logic unused_hi;
  assign cx = sx[OUT_W-1:0];
  assign cy = sy[OUT_W-1:0];
  assign cz = sz[OUT_W-1:0];
  assign unused_hi = ^{sx[SIZE-1:OUT_W], sy[SIZE-1:OUT_W], sz[SIZE-1:OUT_W]};
  assign overflow  = 1'b0;
`endif

  // step comes from registered state only, so m_ready never reaches it combinationally.
  assign step      = (state == RUN);
  assign fsm_state = state;
  assign push      = step && (dec_cnt == '0);
  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;

  assign m_x   = mem_x[rd_ptr];
  assign m_y   = mem_y[rd_ptr];
  assign m_z   = mem_z[rd_ptr];
  assign m_seq = mem_seq[rd_ptr];

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Next-count lookahead lets the filling push enter HOLD on the same edge,
  // and a pop in HOLD resume stepping one cycle later.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = (count_n == FULL) ? HOLD : RUN;
      RUN:     if (!run) state_n = IDLE;
               else if (count_n == FULL) state_n = HOLD;
      HOLD:    if (!run) state_n = IDLE;
               else if (count_n != FULL) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
      seq_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x[i]   <= '0;
        mem_y[i]   <= '0;
        mem_z[i]   <= '0;
        mem_seq[i] <= '0;
      end
    end else begin
      if (step) dec_cnt <= (dec_cnt == '0) ? decim : dec_cnt - 1'b1;
      if (push) begin
        mem_x[wr_ptr]   <= cx;
        mem_y[wr_ptr]   <= cy;
        mem_z[wr_ptr]   <= cz;
        mem_seq[wr_ptr] <= seq_cnt;
        wr_ptr          <= wr_ptr + 1'b1;
        seq_cnt         <= seq_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

endmodule

// File: tb/tb_lorenz_sample_drain.sv
// Directed bench for lorenz_sample_drain: conversion, decimation, backpressure, saturation, reset and drain.
module tb_lorenz_sample_drain;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  decim;
  logic [63:0] x_in, y_in, z_in;
  logic        step, m_valid, m_ready, overflow;
  logic [15:0] m_x, m_y, m_z, m_seq;
  logic [3:0]  count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_seq;

  localparam logic [63:0] V_1P5  = 64'h0001_8000_0000_0000;
  localparam logic [63:0] V_M225 = 64'hFFFD_C000_0000_0000;
  localparam logic [63:0] V_200  = 64'h00C8_0000_0000_0000;
  localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2;

  lorenz_sample_drain dut (
    .clock(clock), .reset(reset), .run(run), .decim(decim),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .step(step), .m_valid(m_valid), .m_ready(m_ready),
    .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_seq(m_seq),
    .count(count), .overflow(overflow), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; decim = '0; m_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; decim = '0; m_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    tick();
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", step); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_x !== 16'h0 || m_y !== 16'h0 || m_z !== 16'h0) begin errors++; $display("FAIL reset_xyz: got %h %h %h want 0", m_x, m_y, m_z); end
    checks++; if (m_seq !== 16'h0) begin errors++; $display("FAIL reset_seq: got %h want 0", m_seq); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    reset = 1'b0;
    tick();
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL idle_step: got %b want 0", step); end
  endtask

  task automatic test_conversion();
    do_reset();
    x_in = V_1P5; y_in = V_M225; z_in = '0; decim = 8'd0; run = 1'b1;
    tick();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL conv_step: got %b want 1", step); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL conv_valid_early: got %b want 0", m_valid); end
    tick();
    run = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL conv_valid: got %b want 1", m_valid); end
    checks++; if (m_x !== 16'h0180) begin errors++; $display("FAIL conv_x: got %h want 0180", m_x); end
    checks++; if (m_y !== 16'hFDC0) begin errors++; $display("FAIL conv_y: got %h want fdc0", m_y); end
    checks++; if (m_z !== 16'h0000) begin errors++; $display("FAIL conv_z: got %h want 0000", m_z); end
    checks++; if (m_seq !== 16'd0) begin errors++; $display("FAIL conv_seq: got %0d want 0", m_seq); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL conv_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_decimation();
    logic [7:0] md;
    logic       pend;
    logic [15:0] seq;
    do_reset();
    md = 0; pend = 0; seq = 0;
    decim = 8'd3; m_ready = 1'b1; run = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL dec_step[%0d]: got %b want 1", j, step); end
      checks++; if (m_valid !== pend) begin errors++; $display("FAIL dec_valid[%0d]: got %b want %b", j, m_valid, pend); end
      if (pend) begin
        exp_seq = exp_q.pop_front();
        checks++; if (m_seq !== exp_seq) begin errors++; $display("FAIL dec_seq[%0d]: got %0d want %0d", j, m_seq, exp_seq); end
      end
      pend = 1'b0;
      if (md == 0) begin exp_q.push_back(seq); seq++; pend = 1'b1; md = decim; end
      else md--;
    end
    run = 1'b0;
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL dec_count_end: got %0d want 0", count); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    decim = 8'd0; m_ready = 1'b0; run = 1'b1;
    n = 0;
    while (count !== 4'd8 && n < 20) begin tick(); n++; end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_fill_timeout: got count %0d want 8", count); end
    repeat (3) tick();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_count_hold: got %0d want 8", count); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL bp_step_hold: got %b want 0", step); end
    checks++; if (fsm_state !== S_HOLD) begin errors++; $display("FAIL bp_state_hold: got %0d want 2", fsm_state); end
    checks++; if (m_seq !== 16'd0) begin errors++; $display("FAIL bp_head0: got %0d want 0", m_seq); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL bp_count7: got %0d want 7", count); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL bp_step_resume: got %b want 1", step); end
    tick();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_refill: got %0d want 8", count); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL bp_step_rehold: got %b want 0", step); end
    for (int k = 1; k <= 8; k++) exp_q.push_back(16'(k));
    run = 1'b0; m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_seq = exp_q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_seq !== exp_seq) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b seq=%0d want v=1 seq=%0d", k, m_valid, m_seq, exp_seq); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    x_in = V_200; decim = 8'd0; run = 1'b1;
    tick(); tick();
    run = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", m_valid); end
`ifdef LORENZ_SAT_EN
    checks++; if (m_x !== 16'h7FFF) begin errors++; $display("FAIL sat_x: got %h want 7fff", m_x); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", overflow); end
`else
    checks++; if (m_x !== 16'hC800) begin errors++; $display("FAIL sat_x: got %h want c800", m_x); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf: got %b want 0", overflow); end
`endif
  endtask

  task automatic test_reset_midstream();
    do_reset();
    decim = 8'd0; m_ready = 1'b0; run = 1'b1;
    repeat (6) tick();
    checks++; if (count !== 4'd5 || step !== 1'b1) begin errors++; $display("FAIL mid_pre: got count=%0d step=%b want 5 1", count, step); end
    reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", m_valid); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL mid_step: got %b want 0", step); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL mid_restart_step: got %b want 1", step); end
    tick();
    run = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_seq !== 16'd0) begin errors++; $display("FAIL mid_first_seq: got v=%b seq=%0d want v=1 seq=0", m_valid, m_seq); end
  endtask

  task automatic test_stop_drain();
    do_reset();
    decim = 8'd0; m_ready = 1'b0; run = 1'b1;
    repeat (4) tick();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL stop_pre_count: got %0d want 3", count); end
    // This cycle still steps: seq 3 is pushed while seq 0 is popped.
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'(k));
    run = 1'b0; m_ready = 1'b1;
    tick();
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL stop_step: got %b want 0", step); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL stop_state: got %0d want 0", fsm_state); end
    for (int k = 0; k < 3; k++) begin
      exp_seq = exp_q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_seq !== exp_seq) begin errors++; $display("FAIL stop_pop[%0d]: got v=%b seq=%0d want v=1 seq=%0d", k, m_valid, m_seq, exp_seq); end
      tick();
    end
    checks++; if (m_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL stop_empty: got v=%b count=%0d want 0 0", m_valid, count); end
    checks++; if (fsm_state !== S_IDLE || step !== 1'b0) begin errors++; $display("FAIL stop_idle: got state=%0d step=%b want 0 0", fsm_state, step); end
    checks++; if (fsm_state === S_RUN) begin errors++; $display("FAIL stop_not_run: got state=%0d", fsm_state); end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_decimation();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_stop_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
